// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 12;
    localparam int unsigned INSTR_W        = 32;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO carrying {instr, pc} entries from fetch to decode.
module fetch_fifo #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [0:DEPTH-1];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = store[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: byte memory filled by the trace loader, PC walker
// streaming {pc, instr} into a FIFO toward decode, redirect and halt handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              done
);

    localparam int unsigned MEM_SIZE = 2 ** ADDR_W;
    localparam int unsigned ENTRY_W  = INSTR_W + ADDR_W;

    logic [7:0]         mem [0:MEM_SIZE-1];
    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] fetch_word;
    logic [ADDR_W-1:0]  redirect_target;
    logic               redirect_act;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               redirect_unused;

    assign redirect_unused = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Little-endian word; each byte address wraps independently.
    assign fetch_word = {mem[pc + ADDR_W'(3)], mem[pc + ADDR_W'(2)],
                         mem[pc + ADDR_W'(1)], mem[pc]};

    assign redirect_act = redirect_valid && (state != S_IDLE);
    assign pop  = !fifo_empty && out_ready && !redirect_act;
    assign push = (state == S_RUN) && (fetch_word != HALT_INSTR)
                  && (!fifo_full || pop) && !redirect_act;

    // Trace loader port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (redirect_act) begin
                        pc <= redirect_target;
                    end else if (fetch_word == HALT_INSTR) begin
                        state <= S_HALT;
                    end else if (push) begin
                        pc <= pc + ADDR_W'(4);
                    end
                end
                S_HALT: begin
                    if (redirect_act) begin
                        state <= S_RUN;
                        pc    <= redirect_target;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_act),
        .din   ({fetch_word, pc}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_instr = fifo_head[ENTRY_W-1:ADDR_W];
    assign out_pc    = fifo_head[ADDR_W-1:0];
    assign done      = (state == S_HALT) && fifo_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// sequences for backpressure, redirect, address wrap and async reset.
module tb_fetch_unit;

    localparam int unsigned AW = 12;

    logic          tb_clk;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          start;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          done;

    int checks;
    int failures;

    typedef struct {
        logic          ready;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic [31:0]   exp_instr;
        logic          exp_done;
    } vec_t;

    vec_t vecs [4];

    fetch_unit #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk            (tb_clk),
        .rst            (rst),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .done           (done)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    function automatic logic [31:0] wordf(input int i);
        return 32'h0010_0013 + 32'(i) * 32'h100;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            load_byte(a + AW'(k), w[8*k +: 8]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        #12;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_pc", 64'(out_pc), 64'd0);
        check("reset_instr", 64'(out_instr), 64'd0);
        step();
        rst = 1'b0;

        // Short program with terminator; per-cycle expectations after start.
        load_word(12'h000, 32'h0050_0093);
        load_word(12'h004, 32'h00A0_0113);
        load_word(12'h008, 32'h0000_0000);
        vecs[0] = '{1'b1, 1'b0, 12'h000, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 12'h000, 32'h0050_0093, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 12'h004, 32'h00A0_0113, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 12'h000, 32'h0, 1'b1};
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            out_ready = vecs[i].ready;
            check($sformatf("t1_valid[%0d]", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("t1_done[%0d]", i), 64'(done), 64'(vecs[i].exp_done));
            if (vecs[i].exp_valid) begin
                check($sformatf("t1_pc[%0d]", i), 64'(out_pc), 64'(vecs[i].exp_pc));
                check($sformatf("t1_instr[%0d]", i), 64'(out_instr), 64'(vecs[i].exp_instr));
            end
            step();
        end

        // Backpressure: fill with ready low, then drain eight entries back to back.
        do_reset();
        for (int i = 0; i < 8; i++) load_word(AW'(4 * i), wordf(i));
        load_word(12'h020, 32'h0);
        out_ready = 1'b0;
        pulse_start();
        step();
        check("t2_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 8; i++) step();
        check("t2_full_valid", 64'(out_valid), 64'd1);
        check("t2_full_pc", 64'(out_pc), 64'd0);
        check("t2_full_instr", 64'(out_instr), 64'(wordf(0)));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_valid[%0d]", i), 64'(out_valid), 64'd1);
            check($sformatf("t2_pc[%0d]", i), 64'(out_pc), 64'(4 * i));
            check($sformatf("t2_instr[%0d]", i), 64'(out_instr), 64'(wordf(i)));
            step();
        end
        check("t2_drained_valid", 64'(out_valid), 64'd0);
        check("t2_done", 64'(done), 64'd1);

        // Redirect mid-stream to an unaligned target.
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        step();
        check("t3_pc0", 64'(out_pc), 64'd0);
        step();
        check("t3_pc4", 64'(out_pc), 64'd4);
        redirect_valid = 1'b1;
        redirect_pc = 12'h013;
        step();
        redirect_valid = 1'b0;
        check("t3_flush_valid", 64'(out_valid), 64'd0);
        step();
        for (int i = 4; i < 8; i++) begin
            check($sformatf("t3_valid[%0d]", i), 64'(out_valid), 64'd1);
            check($sformatf("t3_pc[%0d]", i), 64'(out_pc), 64'(4 * i));
            check($sformatf("t3_instr[%0d]", i), 64'(out_instr), 64'(wordf(i)));
            step();
        end
        check("t3_done", 64'(done), 64'd1);

        // Top-of-memory word, loaded while halted; terminator at 0 after wrap.
        load_word(12'h000, 32'h0);
        load_byte(12'hFFC, 8'hAA);
        load_byte(12'hFFD, 8'hBB);
        load_byte(12'hFFE, 8'hCC);
        load_byte(12'hFFF, 8'hDD);
        check("t4_halt_done", 64'(done), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 12'hFFC;
        step();
        redirect_valid = 1'b0;
        check("t4_run_valid", 64'(out_valid), 64'd0);
        check("t4_run_done", 64'(done), 64'd0);
        step();
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_pc", 64'(out_pc), 64'hFFC);
        check("t4_instr", 64'(out_instr), 64'hDDCC_BBAA);
        step();
        check("t4_done", 64'(done), 64'd1);
        check("t4_end_valid", 64'(out_valid), 64'd0);

        // Async reset with three queued entries, redirect in IDLE, restart.
        do_reset();
        load_word(12'h000, wordf(0));
        out_ready = 1'b0;
        pulse_start();
        step();
        step();
        step();
        check("t6_queued_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_pc", 64'(out_pc), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 12'h010;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_idle_valid[%0d]", i), 64'(out_valid), 64'd0);
            step();
        end
        pulse_start();
        step();
        check("t6_restart_valid", 64'(out_valid), 64'd1);
        check("t6_restart_pc", 64'(out_pc), 64'd0);
        check("t6_restart_instr", 64'(out_instr), 64'(wordf(0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
